// File: rtl/im_loader_if.sv
// Byte-stream load port and instruction-memory write port of the instruction loader.
// The master side supplies commands and bytes; the slave side is the loader itself.
interface im_loader_if;
  logic        start;
  logic [6:0]  word_count;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  modport master (
    output start, word_count, abort, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
  );

  modport slave (
    input  start, word_count, abort, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: assembles big-endian 32-bit words from a byte stream,
// writes them to consecutive word addresses and keeps a running XOR checksum.
module im_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  im_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  cnt_rem;
  logic [7:0]  word_addr;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [7:0]  csum;

  logic        ready_c;
  logic        we_c;
  logic        busy_c;
  logic        done_c;
  logic        start_ok;
  logic        accept;

  function automatic logic [6:0] clamp_count(input logic [6:0] n);
    return (n > 7'(MAX_WORDS)) ? 7'(MAX_WORDS) : n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    we_c      = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done_c = (state == DONE);
        if (bus.start)
          state_nxt = (clamp_count(bus.word_count) == 7'd0) ? DONE : RECV;
      end
      RECV: begin
        busy_c  = 1'b1;
        // Abort wins over a same-cycle byte: the byte is refused outright.
        ready_c = !bus.abort;
        if (bus.abort)
          state_nxt = IDLE;
        else if (bus.byte_valid && byte_idx == 2'd3)
          state_nxt = WRITE;
      end
      WRITE: begin
        busy_c = 1'b1;
        we_c   = 1'b1;
        if (bus.abort)
          state_nxt = IDLE;
        else if (cnt_rem == 7'd1)
          state_nxt = DONE;
        else
          state_nxt = RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start_ok = bus.start && (state == IDLE || state == DONE);
  assign accept   = ready_c && bus.byte_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_rem   <= '0;
      word_addr <= '0;
      byte_idx  <= '0;
      asm_word  <= '0;
      csum      <= '0;
    end else begin
      if (start_ok) begin
        cnt_rem   <= clamp_count(bus.word_count);
        word_addr <= '0;
        byte_idx  <= '0;
        csum      <= '0;
      end
      if (state == RECV && bus.abort) begin
        byte_idx <= '0;
      end else if (accept) begin
        asm_word <= {asm_word[23:0], bus.byte_data};
        csum     <= csum ^ bus.byte_data;
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == WRITE) begin
        cnt_rem <= cnt_rem - 7'd1;
        // Hold the address on the final word so a full 64-word load stops at 0xFC.
        if (cnt_rem != 7'd1)
          word_addr <= word_addr + 8'd4;
      end
    end
  end

  assign bus.byte_ready = ready_c;
  assign bus.mem_we     = we_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.mem_addr   = word_addr;
  assign bus.mem_wdata  = asm_word;
  assign bus.checksum   = csum;

endmodule

// File: tb/tb_im_loader.sv
// Randomized and directed bench for im_loader against a transaction-level loader model.
module tb_im_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  im_loader_if ifc();
  im_loader #(.MAX_WORDS(64)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int we_cyc = -10;
  bit chk_en = 1'b0;

  // Reference model: "loading" a job of m_left words, bytes gathered into a list.
  bit          m_loading;
  bit          m_pend;
  bit          m_done;
  int          m_left;
  logic [7:0]  m_addr;
  logic [7:0]  m_csum;
  logic [31:0] m_word;
  logic [7:0]  m_bytes[$];

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_pend = 0; m_done = 0; m_left = 0;
    m_addr = 0; m_csum = 0; m_word = 0;
    m_bytes.delete();
  endtask

  task automatic model_step();
    int wc;
    if (rst) return;
    if (m_pend) begin
      m_pend = 0;
      m_left--;
      if (ifc.abort) m_loading = 0;
      else if (m_left == 0) begin m_loading = 0; m_done = 1; end
      else m_addr = m_addr + 8'd4;
    end else if (m_loading) begin
      if (ifc.abort) begin
        m_loading = 0;
        m_bytes.delete();
      end else if (ifc.byte_valid) begin
        m_bytes.push_back(ifc.byte_data);
        m_csum = m_csum ^ ifc.byte_data;
        if (m_bytes.size() == 4) begin
          m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_pend = 1;
          m_bytes.delete();
        end
      end
    end else if (ifc.start) begin
      wc = (ifc.word_count > 7'd64) ? 64 : int'(ifc.word_count);
      m_csum = 0; m_addr = 0; m_bytes.delete();
      m_done = (wc == 0);
      m_loading = (wc != 0);
      m_left = wc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("byte_ready", 32'(ifc.byte_ready), 32'(m_loading && !m_pend && !ifc.abort));
      check("mem_we", 32'(ifc.mem_we), 32'(m_pend));
      check("busy", 32'(ifc.busy), 32'(m_loading));
      check("done", 32'(ifc.done), 32'(m_done));
      check("checksum", 32'(ifc.checksum), 32'(m_csum));
      if (m_pend) begin
        check("mem_addr", 32'(ifc.mem_addr), 32'(m_addr));
        check("mem_wdata", ifc.mem_wdata, m_word);
      end
      if (ifc.mem_we) begin
        wa_q.push_back(ifc.mem_addr);
        wd_q.push_back(ifc.mem_wdata);
        we_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    ifc.start = 0; ifc.word_count = 0; ifc.abort = 0;
    ifc.byte_valid = 0; ifc.byte_data = 0;
  endtask

  task automatic do_start(input int wc);
    ifc.word_count = 7'(wc);
    ifc.start = 1;
    tick();
    ifc.start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      ifc.byte_valid = 0;
      repeat (gap) tick();
    end
    ifc.byte_valid = 1;
    ifc.byte_data = b;
    t = 0;
    while (!ifc.byte_ready && t < 20) begin tick(); t++; end
    if (t >= 20) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: byte_ready stayed %0b, expected 1 at t=%0t", ifc.byte_ready, $time);
    end
    acc_cyc = cyc;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  logic [7:0] basic_bytes[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00};

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    chk_en = 1;
    repeat (2) tick();
    check("rst_busy", 32'(ifc.busy), 0);
    check("rst_done", 32'(ifc.done), 0);
    check("rst_we", 32'(ifc.mem_we), 0);
    check("rst_ready", 32'(ifc.byte_ready), 0);
    check("rst_addr", 32'(ifc.mem_addr), 0);
    check("rst_wdata", ifc.mem_wdata, 0);
    check("rst_csum", 32'(ifc.checksum), 0);
    rst = 0;
    repeat (2) tick();

    // Basic two-word load, source never stalls
    clear_log();
    do_start(2);
    for (int i = 0; i < 8; i++) send_byte(basic_bytes[i], 0);
    ifc.byte_valid = 0;
    repeat (3) tick();
    check("basic_nwr", 32'(wa_q.size()), 2);
    if (wa_q.size() == 2) begin
      check("basic_a0", 32'(wa_q[0]), 32'h00);
      check("basic_d0", wd_q[0], 32'h20080005);
      check("basic_a1", 32'(wa_q[1]), 32'h04);
      check("basic_d1", wd_q[1], 32'hAC020000);
    end
    check("basic_done", 32'(ifc.done), 1);
    check("basic_busy", 32'(ifc.busy), 0);
    check("basic_csum", 32'(ifc.checksum), 32'h83);

    // Stalled source: three idle cycles between bytes
    clear_log();
    do_start(1);
    send_word(32'h12345678, 3);
    ifc.byte_valid = 0;
    repeat (3) tick();
    check("stall_nwr", 32'(wa_q.size()), 1);
    if (wa_q.size() == 1) begin
      check("stall_a0", 32'(wa_q[0]), 0);
      check("stall_d0", wd_q[0], 32'h12345678);
    end
    check("stall_latency", 32'(we_cyc), 32'(acc_cyc + 1));

    // Zero-length load and clamp to 64 words
    clear_log();
    do_start(0);
    check("zero_done", 32'(ifc.done), 1);
    check("zero_busy", 32'(ifc.busy), 0);
    repeat (3) tick();
    check("zero_nwr", 32'(wa_q.size()), 0);
    do_start(100);
    for (int i = 0; i < 256; i++) send_byte(8'($urandom), int'($urandom_range(0, 1)));
    ifc.byte_valid = 0;
    repeat (3) tick();
    check("clamp_nwr", 32'(wa_q.size()), 64);
    if (wa_q.size() == 64) check("clamp_last_addr", 32'(wa_q[63]), 32'hFC);
    check("clamp_done", 32'(ifc.done), 1);

    // Abort together with the second byte of word 1
    clear_log();
    do_start(2);
    send_word($urandom, 0);
    send_byte(8'($urandom), 0);
    ifc.byte_valid = 1;
    ifc.byte_data = 8'($urandom);
    ifc.abort = 1;
    tick();
    ifc.abort = 0;
    ifc.byte_valid = 0;
    repeat (3) tick();
    check("abort_nwr", 32'(wa_q.size()), 1);
    if (wa_q.size() == 1) check("abort_a0", 32'(wa_q[0]), 0);
    check("abort_busy", 32'(ifc.busy), 0);
    check("abort_done", 32'(ifc.done), 0);
    clear_log();
    do_start(1);
    send_word(32'hDEADBEEF, 1);
    ifc.byte_valid = 0;
    repeat (3) tick();
    check("reload_nwr", 32'(wa_q.size()), 1);
    if (wa_q.size() == 1) begin
      check("reload_a0", 32'(wa_q[0]), 0);
      check("reload_d0", wd_q[0], 32'hDEADBEEF);
    end

    // Reset in the middle of a load
    clear_log();
    do_start(2);
    send_byte(8'h5A, 0);
    send_byte(8'hC3, 0);
    ifc.byte_valid = 0;
    rst = 1;
    model_reset();
    #1;
    check("mrst_busy", 32'(ifc.busy), 0);
    check("mrst_ready", 32'(ifc.byte_ready), 0);
    check("mrst_csum", 32'(ifc.checksum), 0);
    check("mrst_wdata", ifc.mem_wdata, 0);
    repeat (2) tick();
    rst = 0;
    repeat (3) tick();
    check("mrst_nwr", 32'(wa_q.size()), 0);
    do_start(1);
    repeat (10) tick();
    check("mrst_wait_busy", 32'(ifc.busy), 1);
    check("mrst_wait_nwr", 32'(wa_q.size()), 0);
    ifc.abort = 1;
    tick();
    ifc.abort = 0;
    tick();

    // Start while busy is ignored
    clear_log();
    do_start(2);
    send_byte(8'h11, 0);
    ifc.start = 1;
    ifc.word_count = 7'd5;
    send_byte(8'h22, 0);
    ifc.start = 0;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'h55667788, 0);
    ifc.byte_valid = 0;
    repeat (3) tick();
    check("ign_nwr", 32'(wa_q.size()), 2);
    if (wa_q.size() == 2) check("ign_d0", wd_q[0], 32'h11223344);
    check("ign_done", 32'(ifc.done), 1);

    // Free-running random traffic
    for (int i = 0; i < 4000; i++) begin
      ifc.start = ($urandom_range(0, 5) == 0);
      ifc.word_count = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(65, 127))
                                                   : 7'($urandom_range(0, 5));
      ifc.abort = ($urandom_range(0, 39) == 0);
      ifc.byte_valid = $urandom_range(0, 1) == 1;
      ifc.byte_data = 8'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1;
        model_reset();
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end
    idle_inputs();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64, maximum words per load; 64 words fill the 256-byte instruction space.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  begin-load request, sampled only in IDLE or DONE.
REQ-005 WordCount  input  7  number of 32-bit words to load, latched on accepted Start; legal range 0..64.
REQ-006 Abort  input  1  cancel the load in progress.
REQ-007 ByteValid  input  1  source has a byte on ByteData.
REQ-008 ByteData  input  8  incoming program byte, most-significant byte of each word first.
REQ-009 ByteReady  output  1  loader accepts a byte this cycle.
REQ-010 MemWE  output  1  one-cycle word-write strobe to instruction memory.
REQ-011 MemAddr  output  8  byte address of the word being written; always a multiple of 4.
REQ-012 MemWData  output  32  big-endian word {byte0,byte1,byte2,byte3}; byte0 is stored at MemAddr, byte3 at MemAddr+3.
REQ-013 Busy  output  1  load in progress; CPU held off instruction fetch while high.
REQ-014 Done  output  1  last load completed normally.
REQ-015 Checksum  output  8  XOR of all bytes accepted in the current or last load.

Function
REQ-016 FSM states SHALL be IDLE, RECV, WRITE and DONE.
REQ-017 IDLE/DONE + Start=1 SHALL move to RECV with these actions:
- latch WordCount;
- clear the word address, byte index and Checksum;
- clear Done.
REQ-018 Start with WordCount=0 SHALL go directly to DONE with Done=1, no MemWE pulse, Checksum=0.
REQ-019 WordCount>64 SHALL be clamped to 64.
REQ-020 ByteReady SHALL be 1 only in RECV.
- A byte is accepted on a cycle with ByteValid=1 and ByteReady=1.
- Each accepted byte is shifted into the assembly register (first byte lands at bits 31:24) and XORed into Checksum.
REQ-021 The fourth accepted byte of a word SHALL move RECV to WRITE; MemWE SHALL be 1 for exactly the following cycle.
- MemAddr and MemWData are valid in that same cycle.
- Latency: last byte accepted in cycle N, MemWE high in cycle N+1.
REQ-022 WRITE actions:
- ByteReady=0.
- After the write, MemAddr advances by 4 and the remaining-word count decrements.
- Next state is DONE if the remaining count reaches 0, else RECV.
- Peak throughput is one word per 5 cycles.
REQ-023 Busy SHALL be 1 in RECV and WRITE, 0 in IDLE and DONE.
REQ-024 Done SHALL be 1 only in DONE; it holds until the next accepted Start or reset.
REQ-025 Abort in RECV SHALL take priority over a same-cycle byte:
- that byte is not accepted (ByteReady forced 0);
- the partial word is discarded;
- the next state is IDLE with Done=0.
REQ-026 Abort in WRITE SHALL let that cycle's write complete, then go to IDLE with Done=0.
REQ-027 Abort in IDLE or DONE SHALL be ignored; Start while Busy SHALL be ignored.
REQ-028 ByteValid may stall arbitrarily between bytes; the loader SHALL hold state without timeout.
REQ-029 MemAddr SHALL never wrap: 64 words end at byte address 252.
REQ-030 MemWE SHALL be 0 in every state except WRITE.

Reset
REQ-031 rst=1 SHALL asynchronously force:
- state IDLE;
- ByteReady=0, MemWE=0, Busy=0, Done=0;
- MemAddr=0, MemWData=0, Checksum=0;
- word address, byte index and remaining-word count to 0.
REQ-032 Reset asserted mid-load SHALL abandon the load with no further MemWE pulse; the loader waits in IDLE for a new Start after release.

Verification
REQ-033 Basic load: Start with WordCount=2, bytes 20,08,00,05,AC,02,00,00 with ByteValid held high.
- Expected: MemWE pulse at addr 0x00 with data 0x20080005.
- Expected: MemWE pulse at addr 0x04 with data 0xAC020000.
- Expected: Done=1, Busy=0, Checksum=0x83.
REQ-034 Stalled source: WordCount=1, ByteValid low for 3 cycles between each byte of 12,34,56,78.
- Expected: exactly one MemWE, data 0x12345678, addr 0x00.
- Expected: MemWE occurs the cycle after the 4th byte is accepted.
REQ-035 Zero and clamp: Start with WordCount=0 -> Done=1 next cycle, no MemWE. Start with WordCount=100 -> 64 writes, last at addr 0xFC.
REQ-036 Abort: WordCount=2, Abort asserted together with the 2nd byte of word 1.
- Expected: word 0 written at 0x00; no write at 0x04; IDLE, Done=0.
- Expected: a following Start with WordCount=1 writes at 0x00.
REQ-037 Reset mid-load: rst pulsed during RECV after 2 bytes.
- Expected: all outputs 0 immediately; no MemWE afterwards.
- Expected: a Start with ByteValid held low leaves Busy=1 with no write.
REQ-038 Start ignored while Busy: Start pulsed during RECV -> latched WordCount unchanged and load completes normally.
